// File: rtl/serial_master_port.sv
// serial_master_port: serial bus master bridge; optional ack/read-bit timeout via SERIAL_MASTER_TIMEOUT_EN
module serial_master_port #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  m_breq,
  input  logic                  m_bgrant,
  output logic                  m_mode,
  output logic                  m_wvalid,
  output logic                  m_wdata,
  input  logic                  m_rvalid,
  input  logic                  m_rdata,
  input  logic                  m_ack,
  input  logic                  m_split
);
  localparam int MW = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(MW) + 1;
  typedef enum logic [2:0] {IDLE, REQ, ADDR, ACK_WAIT, WDATA, RDATA, SPLIT, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic mode_q, split_rd, tmo_hit, err_q, cap, adv, last_a, last_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q, rdata_next, rsp_rdata_q;
  assign last_a = cnt == CW'(ADDR_WIDTH - 1);
  assign last_d = cnt == CW'(DATA_WIDTH - 1);
`ifdef SERIAL_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  logic [TW-1:0] tmo;
  assign tmo_hit = tmo == TW'(ACK_TIMEOUT - 1) && m_bgrant && !m_split &&
                   ((state == ACK_WAIT && !m_ack) || (state == RDATA && !m_rvalid));
  // idle-cycle counter restarts on every state change and every received read bit
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo   <= '0;
      err_q <= 1'b0;
    end else begin
      tmo   <= (state_d != state || (state != ACK_WAIT && state != RDATA) || (state == RDATA && m_rvalid)) ? '0 : tmo + 1'b1;
      err_q <= tmo_hit;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_q   = 1'b0;
`endif
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (req_valid) state_d = REQ;
      REQ:      if (m_bgrant) state_d = ADDR;
      ADDR:     state_d = !m_bgrant ? REQ : last_a ? ACK_WAIT : ADDR;
      ACK_WAIT: state_d = m_split ? SPLIT : !m_bgrant ? REQ : m_ack ? (mode_q ? WDATA : RDATA) : tmo_hit ? DONE : ACK_WAIT;
      WDATA:    state_d = !m_bgrant ? REQ : last_d ? DONE : WDATA;
      RDATA:    state_d = m_split ? SPLIT : !m_bgrant ? REQ : ((m_rvalid && last_d) || tmo_hit) ? DONE : RDATA;
      SPLIT:    if (!m_split && m_bgrant) state_d = split_rd ? RDATA : ACK_WAIT;
      default:  state_d = IDLE;
    endcase
  end
  // bit count survives a split; any other phase change restarts it
  assign adv        = state == ADDR || state == WDATA || (state == RDATA && m_rvalid);
  assign cnt_d      = (state == SPLIT || state_d == SPLIT) ? cnt : (state_d != state) ? '0 : cnt + CW'(adv);
  assign cap        = state == RDATA && m_rvalid && (state_d == RDATA || state_d == DONE);
  assign rdata_next = (rdata_q & ~(DATA_WIDTH'(1) << cnt)) | (DATA_WIDTH'(m_rdata) << cnt);
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      mode_q      <= 1'b0;
      split_rd    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == IDLE && req_valid) begin
        mode_q  <= req_mode;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (cap) rdata_q <= rdata_next;
      if (cap && state_d == DONE) rsp_rdata_q <= rdata_next;
      if (state_d == SPLIT && state != SPLIT) split_rd <= state == RDATA;
    end
  end
  assign req_ready = state == IDLE;
  assign m_breq    = state != IDLE && state != DONE;
  assign m_wvalid  = state == ADDR || state == WDATA;
  assign m_mode    = state == ADDR && mode_q;
  assign m_wdata   = state == ADDR  ? |(addr_q & (ADDR_WIDTH'(1) << cnt)) :
                     state == WDATA ? |(wdata_q & (DATA_WIDTH'(1) << cnt)) : 1'b0;
  assign rsp_valid = state == DONE;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = state == DONE && err_q;
endmodule

// File: tb/tb_serial_master_port.sv
// tb_serial_master_port: acts as arbiter and slave, rebuilds serial frames and checks them against each request
module tb_serial_master_port;
  localparam int AW = 16;
  localparam int DW = 8;
  logic clk = 0, rstn = 0;
  logic req_valid = 0, req_mode = 0, m_bgrant = 0, m_rvalid = 0, m_rdata = 0, m_ack = 0, m_split = 0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err, m_breq, m_mode, m_wvalid, m_wdata;
  logic [DW-1:0] rsp_rdata;
  int checks = 0, failures = 0, cyc = 0;
  logic [DW-1:0] last_rd = '0;

  serial_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACK_TIMEOUT(32)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .m_breq(m_breq), .m_bgrant(m_bgrant), .m_mode(m_mode), .m_wvalid(m_wvalid),
    .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_ack(m_ack), .m_split(m_split));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full transaction seen from the bus side; split_at/gap_at/glitch_at beyond range mean "none".
  task automatic txn(input bit mode, input logic [AW-1:0] addr, input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                     input int ack_dly, input int gap_at, input int gap_len, input int split_at, input int split_len,
                     input int ack_split, input int glitch_at, input bit hold);
    logic [AW-1:0] got_a;
    logic [DW-1:0] got_d;
    int n, b, t0;
    bit g;
    got_a = '0;
    got_d = '0;
    req_valid = 1; req_mode = mode; req_addr = addr; req_wdata = wd; m_bgrant = 1;
    chk("ready_idle", req_ready, 1);
    tick();
    if (!hold) req_valid = 0;
    t0 = cyc;
    chk("breq_req", m_breq, 1);
    chk("ready_busy", req_ready, 0);
    n = 0; b = 0; g = 0;
    while (n < AW && b < 200) begin
      if (m_wvalid && n == glitch_at && !g) begin
        g = 1; m_bgrant = 0;
        tick();
        m_bgrant = 1; n = 0;
        chk("glitch_breq", m_breq, 1);
        chk("glitch_wvalid", m_wvalid, 0);
      end else begin
        if (m_wvalid) begin
          got_a[n] = m_wdata;
          if (n == 0) chk("addr_mode", m_mode, mode);
          n++;
        end
        tick();
      end
      b++;
    end
    chk("addr_len", n, AW);
    chk("addr", got_a, addr);
    chk("ackwait_wvalid", m_wvalid, 0);
    if (ack_split > 0) begin
      m_split = 1; m_bgrant = 0;
      repeat (ack_split) tick();
      chk("ack_split_breq", m_breq, 1);
      m_split = 0; m_bgrant = 1;
      tick();
    end
    for (int i = 0; i < ack_dly; i++) begin
      if (i == 0 || i == ack_dly - 1) chk("ackwait_norsp", rsp_valid, 0);
      tick();
    end
    m_ack = 1;
    tick();
    m_ack = 0;
    if (mode) begin
      n = 0; b = 0;
      while (n < DW && b < 50) begin
        if (m_wvalid) begin got_d[n] = m_wdata; n++; end
        tick();
        b++;
      end
      chk("wdata_len", n, DW);
      chk("wdata", got_d, wd);
      if (glitch_at >= AW && ack_split == 0) chk("latency", cyc - t0, AW + DW + 2 + ack_dly);
    end else begin
      for (int i = 0; i < DW; i++) begin
        if (i == split_at) begin
          m_split = 1; m_bgrant = 0;
          for (int k = 0; k < split_len; k++) begin
            tick();
            if (m_breq !== 1'b1 || rsp_valid !== 1'b0) chk("split_hold", {m_breq, rsp_valid}, 2'b10);
          end
          chk("split_breq", m_breq, 1);
          m_split = 0; m_bgrant = 1;
          tick();
        end
        if (i == gap_at) repeat (gap_len) tick();
        m_rvalid = 1; m_rdata = rd[i];
        tick();
        m_rvalid = 0;
      end
      last_rd = rd;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, 0);
    chk("rsp_rdata", rsp_rdata, last_rd);
    chk("done_breq", m_breq, 0);
    chk("done_ready", req_ready, 0);
    tick();
    chk("rsp_pulse", rsp_valid, 0);
    chk("ready_after", req_ready, 1);
  endtask

  initial begin
    int n, b;
    repeat (3) tick();
    chk("rst_ready", req_ready, 1);
    chk("rst_outs", {m_breq, m_wvalid, m_wdata, m_mode, rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rstn = 1;
    tick();
    txn(1, 16'h1234, 8'hA5, 0, 1, 99, 0, 99, 0, 0, 99, 0);
    txn(0, 16'h0042, 0, 8'h3C, 0, 4, 2, 99, 0, 0, 99, 0);
    txn(0, 16'hBEEF, 0, 8'h96, 2, 99, 0, 3, 20, 0, 99, 0);
    txn(1, 16'h00FF, 8'h5A, 0, 0, 99, 0, 99, 0, 0, 99, 1);
    txn(1, 16'h8001, 8'hC3, 0, 0, 99, 0, 99, 0, 0, 99, 0);
    txn(0, 16'h7E81, 0, 8'h81, 1, 99, 0, 99, 0, 3, 99, 0);
    txn(1, 16'hA5A5, 8'h0F, 0, 0, 99, 0, 99, 0, 0, 5, 0);
`ifndef SERIAL_MASTER_TIMEOUT_EN
    txn(0, 16'h1111, 0, 8'hE7, 40, 99, 0, 99, 0, 0, 99, 0);
`endif
    // reset while address bit 7 is on the wire
    req_valid = 1; req_mode = 1; req_addr = 16'($urandom); req_wdata = 8'h55; m_bgrant = 1;
    tick();
    req_valid = 0;
    n = 0; b = 0;
    while (b < 50 && !(m_wvalid && n == 7)) begin
      if (m_wvalid) n++;
      tick();
      b++;
    end
    chk("rst_reach_bit7", n, 7);
    rstn = 0;
    tick();
    chk("midrst_outs", {m_breq, m_wvalid, m_wdata, m_mode, rsp_valid, rsp_err}, 0);
    chk("midrst_ready", req_ready, 1);
    chk("midrst_rdata", rsp_rdata, 0);
    last_rd = '0;
    rstn = 1;
    tick();
    chk("postrst_norsp", rsp_valid, 0);
    chk("postrst_breq", m_breq, 0);
`ifdef SERIAL_MASTER_TIMEOUT_EN
    req_valid = 1; req_mode = 0; req_addr = 16'h2222; m_bgrant = 1;
    tick();
    req_valid = 0;
    n = 0; b = 0;
    while (n < AW && b < 100) begin
      if (m_wvalid) n++;
      tick();
      b++;
    end
    b = 0;
    while (!rsp_valid && b < 60) begin
      tick();
      b++;
    end
    chk("tmo_cycles", b, 32);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_breq", m_breq, 0);
    chk("tmo_rdata", rsp_rdata, last_rd);
    tick();
    chk("tmo_ready", req_ready, 1);
`endif
    for (int i = 0; i < 10; i++) begin
      int sp, ga;
      sp = $urandom_range(0, 12);
      ga = $urandom_range(0, 12);
      txn(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 3),
          ga, $urandom_range(0, 3), sp, $urandom_range(1, 5), 0, 99, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
